// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if -- bundle between the requesters / UART transmitter and
// the uart_tx_sched arbiter.
//   req       requester i has a byte valid on req_data[i*DW +: DW]
//   req_data  packed bytes, one DW slice per requester
//   req_last  byte of requester i closes its message
//   req_ack   one-cycle pulse, byte of requester i accepted
//   grant     one-hot current owner, zero when idle
//   tx_start  one-cycle pulse launching a UART frame
//   tx_data   byte for the transmitter, stable for the whole frame
//   tx_done   one-cycle pulse from the transmitter after the stop bit
//   busy      scheduler not idle
//   err       one-cycle pulse on hold timeout abort
// modport master: requester/transmitter side; modport slave: the scheduler.
interface uart_tx_sched_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ack;
    logic [NREQ-1:0]    grant;
    logic               tx_start;
    logic [DW-1:0]      tx_data;
    logic               tx_done;
    logic               busy;
    logic               err;

    modport master (
        output req, req_data, req_last, tx_done,
        input  req_ack, grant, tx_start, tx_data, busy, err
    );

    modport slave (
        input  req, req_data, req_last, tx_done,
        output req_ack, grant, tx_start, tx_data, busy, err
    );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched -- round-robin scheduler sharing one UART transmitter between
// NREQ requesters. A requester that wins keeps the transmitter until it sends
// a byte flagged last (message lock) or stalls longer than HOLD_TO cycles.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   uart_tx_sched_if.slave (requests, acks, grant, transmitter link)
// All outputs are registered.
module uart_tx_sched #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int GAP_CYC = 2,
    parameter int HOLD_TO = 1024
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_sched_if.slave  bus
);
    localparam int PW = $clog2(NREQ);
    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam int HW = $clog2(HOLD_TO + 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, GAP, HOLD} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [PW-1:0]   owner, owner_n;
    logic            last_r, last_n;
    logic [GW-1:0]   gap_cnt, gap_n;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic [NREQ-1:0] grant, grant_n;
    logic [NREQ-1:0] req_ack;
    logic            tx_start;
    logic [DW-1:0]   tx_data, data_n;
    logic            busy;
    logic            err, err_n;

    logic            found;
    logic [PW-1:0]   win;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   next_owner;
    logic            gap_exit;

    assign bus.req_ack  = req_ack;
    assign bus.grant    = grant;
    assign bus.tx_start = tx_start;
    assign bus.tx_data  = tx_data;
    assign bus.busy     = busy;
    assign bus.err      = err;

    assign next_owner = PW'((int'(owner) + 1) % NREQ);

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        owner_n  = owner;
        last_n   = last_r;
        gap_n    = gap_cnt;
        hold_n   = hold_cnt;
        grant_n  = grant;
        data_n   = tx_data;
        err_n    = 1'b0;
        gap_exit = 1'b0;

        // first asserted request at or above ptr, wrapping modulo NREQ
        found = 1'b0;
        win   = ptr;
        cand  = ptr;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_n      = LOAD;
                    owner_n      = win;
                    grant_n      = '0;
                    grant_n[win] = 1'b1;
                    data_n       = bus.req_data[int'(win)*DW +: DW];
                    last_n       = bus.req_last[win];
                end
            end
            LOAD: state_n = WAIT;
            WAIT: begin
                if (bus.tx_done) begin
                    if (GAP_CYC == 0) begin
                        gap_exit = 1'b1;
                    end else begin
                        state_n = GAP;
                        gap_n   = '0;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYC - 1)) gap_exit = 1'b1;
                else                             gap_n    = gap_cnt + GW'(1);
            end
            HOLD: begin
                // message lock: only the owner is looked at
                if (bus.req[owner]) begin
                    state_n = LOAD;
                    data_n  = bus.req_data[int'(owner)*DW +: DW];
                    last_n  = bus.req_last[owner];
                end else if (hold_cnt == HW'(HOLD_TO - 1)) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                    grant_n = '0;
                    ptr_n   = next_owner;
                    hold_n  = '0;
                end else begin
                    hold_n = hold_cnt + HW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // end of inter-frame gap: release after the last byte, else lock
        if (gap_exit) begin
            gap_n = '0;
            if (last_r) begin
                state_n = IDLE;
                grant_n = '0;
                ptr_n   = next_owner;
            end else begin
                state_n = HOLD;
                hold_n  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            last_r   <= 1'b0;
            gap_cnt  <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            req_ack  <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            last_r   <= last_n;
            gap_cnt  <= gap_n;
            hold_cnt <= hold_n;
            grant    <= grant_n;
            req_ack  <= (state_n == LOAD) ? grant_n : '0;
            tx_start <= (state_n == LOAD);
            tx_data  <= data_n;
            busy     <= (state_n != IDLE);
            err      <= err_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched -- bench for uart_tx_sched: transaction-level reference
// model, per-cycle output compare, directed scenarios and random traffic.
module tb_uart_tx_sched;
    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int GAP_CYC = 2;
    localparam int HOLD_TO = 24;

    logic clk;
    logic rst;

    uart_tx_sched_if #(.NREQ(NREQ), .DW(DW)) bus();

    uart_tx_sched #(.NREQ(NREQ), .DW(DW), .GAP_CYC(GAP_CYC), .HOLD_TO(HOLD_TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model (message-level view) ----------------
    int  m_owner = -1;   // -1: nobody owns the transmitter
    int  m_ptr   = 0;
    int  m_gap   = 0;    // gap cycles still to run
    int  m_hold  = 0;    // cycles the owner has been silent while locked
    bit  m_last  = 0;
    bit  m_loading = 0;
    bit  m_waiting = 0;
    logic [NREQ-1:0] e_grant = '0, e_ack = '0;
    logic            e_start = 0, e_busy = 0, e_err = 0;
    logic [DW-1:0]   e_data = '0;

    task take_byte(input int i);
        e_data    = bus.req_data[i*DW +: DW];
        m_last    = bus.req_last[i];
        e_start   = 1'b1;
        e_ack[i]  = 1'b1;
        m_loading = 1'b1;
    endtask

    task release_owner();
        if (m_last) begin
            m_ptr   = (m_owner + 1) % NREQ;
            m_owner = -1;
        end else begin
            m_hold = 0;
        end
    endtask

    always @(posedge clk) begin
        e_ack   = '0;
        e_start = 1'b0;
        e_err   = 1'b0;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_gap = 0; m_hold = 0;
            m_last = 0; m_loading = 0; m_waiting = 0; e_data = '0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++)
                if (m_owner < 0 && bus.req[(m_ptr + k) % NREQ]) begin
                    m_owner = (m_ptr + k) % NREQ;
                    take_byte(m_owner);
                end
        end else if (m_loading) begin
            m_loading = 0;
            m_waiting = 1;
        end else if (m_waiting) begin
            if (bus.tx_done) begin
                m_waiting = 0;
                if (GAP_CYC == 0) release_owner();
                else              m_gap = GAP_CYC;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) release_owner();
        end else if (bus.req[m_owner]) begin
            take_byte(m_owner);
        end else begin
            m_hold++;
            if (m_hold == HOLD_TO) begin
                e_err   = 1'b1;
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end
        e_grant = '0;
        if (m_owner >= 0) e_grant[m_owner] = 1'b1;
        e_busy = (m_owner >= 0);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        n_cmp++;
        if (bus.grant !== e_grant || bus.req_ack !== e_ack || bus.tx_start !== e_start ||
            bus.tx_data !== e_data || bus.busy !== e_busy || bus.err !== e_err) begin
            n_bad++;
            $display("FAIL model_cycle t=%0t got/required: grant %b/%b ack %b/%b start %b/%b data %h/%h busy %b/%b err %b/%b",
                     $time, bus.grant, e_grant, bus.req_ack, e_ack, bus.tx_start, e_start,
                     bus.tx_data, e_data, bus.busy, e_busy, bus.err, e_err);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    bit rand_mode = 0;
    bit inflight  = 0;
    int done_dly  = 0;
    int rem[NREQ];
    int wcnt[NREQ];

    task automatic drive_requesters();
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_ack[i]) begin
                bus.req[i] = 1'b0;
                rem[i]--;
                if (rem[i] > 0)
                    wcnt[i] = ($urandom_range(0, 11) == 0) ? HOLD_TO + 8 : int'($urandom_range(0, 3));
                else
                    wcnt[i] = int'($urandom_range(0, 12));
            end else if (!bus.req[i]) begin
                if (wcnt[i] > 0) wcnt[i]--;
                else begin
                    if (rem[i] <= 0) rem[i] = int'($urandom_range(1, 4));
                    bus.req[i]               = 1'b1;
                    bus.req_data[i*DW +: DW] = DW'($urandom);
                    bus.req_last[i]          = (rem[i] == 1);
                end
            end
        end
    endtask

    // one clock: transmitter reacts to tx_start, then requesters (random mode)
    task automatic step();
        @(negedge clk);
        bus.tx_done = 1'b0;
        if (bus.tx_start) begin
            inflight = 1;
            done_dly = rand_mode ? int'($urandom_range(1, 6)) : 3;
        end else if (inflight) begin
            if (done_dly <= 1) begin
                bus.tx_done = 1'b1;
                inflight    = 0;
            end else done_dly--;
        end else if (rand_mode && $urandom_range(0, 15) == 0) begin
            bus.tx_done = 1'b1;
        end
        if (rand_mode) drive_requesters();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        inflight = 0;
        bus.tx_done = 1'b0;
        bus.req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        step();
        while (!bus.tx_start && n < 40) begin step(); n++; end
        if (!bus.tx_start) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        step();
        while (!bus.tx_done && n < 40) begin step(); n++; end
        if (!bus.tx_done) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic count_to_start(output int n);
        n = 0;
        while (!bus.tx_start && n < 40) begin step(); n++; end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int acks;
        rst = 1'b1;
        bus.req = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_done = 1'b0;
        for (int i = 0; i < NREQ; i++) begin rem[i] = 0; wcnt[i] = 0; end

        // reset state
        do_reset();
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_data", 32'(bus.tx_data), 32'd0);

        // single byte from requester 1, presented right as rst falls
        bus.req[1] = 1'b1; bus.req_data[1*DW +: DW] = 8'h4A; bus.req_last[1] = 1'b1;
        step();
        check("t1_start", 32'(bus.tx_start), 32'd1);
        check("t1_ack", 32'(bus.req_ack), 32'b0010);
        check("t1_data", 32'(bus.tx_data), 32'h4A);
        bus.req[1] = 1'b0;
        wait_done("t1_done");
        step(); step();
        check("t1_gap_grant", 32'(bus.grant), 32'b0010);
        step();
        check("t1_idle_grant", 32'(bus.grant), 32'd0);
        check("t1_idle_busy", 32'(bus.busy), 32'd0);
        check("t1_model_ptr", 32'(m_ptr), 32'd2);

        // round-robin with all four requesting single-byte messages
        do_reset();
        bus.req = 4'b1111; bus.req_last = 4'b1111; bus.req_data = 32'h44332211;
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            wait_start("t2_start");
            check($sformatf("t2_grant%0d", k), 32'(bus.grant), 32'(1 << (k % 4)));
            check($sformatf("t2_ack%0d", k), 32'(bus.req_ack), 32'(1 << (k % 4)));
            if (bus.req_ack != 0) acks++;
            step();
            check($sformatf("t2_ackpulse%0d", k), 32'(bus.req_ack), 32'd0);
        end
        check("t2_ack_count", 32'(acks), 32'd5);
        bus.req = '0;

        // message lock: three bytes from 0 while 2 is waiting
        do_reset();
        bus.req = 4'b0101; bus.req_last = 4'b0100;
        bus.req_data[0 +: DW] = 8'h4A; bus.req_data[2*DW +: DW] = 8'h77;
        step();
        check("t3_grant_a", 32'(bus.grant), 32'b0001);
        check("t3_data_a", 32'(bus.tx_data), 32'h4A);
        bus.req_data[0 +: DW] = 8'h31;
        wait_done("t3_done_a");
        count_to_start(n);
        check("t3_spacing_b", 32'(n), 32'(GAP_CYC + 2));
        check("t3_grant_b", 32'(bus.grant), 32'b0001);
        check("t3_data_b", 32'(bus.tx_data), 32'h31);
        bus.req_data[0 +: DW] = 8'h0D; bus.req_last[0] = 1'b1;
        wait_done("t3_done_b");
        count_to_start(n);
        check("t3_data_c", 32'(bus.tx_data), 32'h0D);
        bus.req[0] = 1'b0;
        wait_done("t3_done_c");
        count_to_start(n);
        check("t3_grant_next", 32'(bus.grant), 32'b0100);
        check("t3_ack_next", 32'(bus.req_ack), 32'b0100);
        bus.req[2] = 1'b0;

        // hold timeout: owner 3 sends a non-last byte then goes silent
        do_reset();
        bus.req[3] = 1'b1; bus.req_last[3] = 1'b0; bus.req_data[3*DW +: DW] = 8'h55;
        step();
        check("t4_grant", 32'(bus.grant), 32'b1000);
        bus.req[3] = 1'b0;
        wait_done("t4_done");
        n = 0;
        while (!bus.err && n < HOLD_TO + 20) begin step(); n++; end
        check("t4_err_latency", 32'(n), 32'(GAP_CYC + 1 + HOLD_TO));
        check("t4_grant_clr", 32'(bus.grant), 32'd0);
        check("t4_model_ptr", 32'(m_ptr), 32'd0);
        step();
        check("t4_err_pulse", 32'(bus.err), 32'd0);
        bus.req = 4'b1001; bus.req_last = 4'b1001;
        step();
        check("t4_ptr_wrap", 32'(bus.grant), 32'b0001);

        // stray tx_done in IDLE and in LOAD
        do_reset();
        bus.tx_done = 1'b1;
        step();
        check("t5_idle_busy", 32'(bus.busy), 32'd0);
        check("t5_idle_ack", 32'(bus.req_ack), 32'd0);
        bus.req[1] = 1'b1; bus.req_last[1] = 1'b1; bus.req_data[1*DW +: DW] = 8'h3C;
        step();
        check("t5_load_start", 32'(bus.tx_start), 32'd1);
        bus.req[1] = 1'b0;
        bus.tx_done = 1'b1;
        step();
        check("t5_wait_busy", 32'(bus.busy), 32'd1);
        check("t5_wait_ack", 32'(bus.req_ack), 32'd0);
        wait_done("t5_done");
        step(); step(); step();
        check("t5_release", 32'(bus.grant), 32'd0);

        // reset in the middle of a frame
        do_reset();
        bus.req = 4'b0110; bus.req_last = 4'b0110;
        bus.req_data[1*DW +: DW] = 8'h11; bus.req_data[2*DW +: DW] = 8'h22;
        step();
        check("t6_grant_a", 32'(bus.grant), 32'b0010);
        bus.req[1] = 1'b0;
        step();
        rst = 1'b1; inflight = 0;
        step();
        check("t6_rst_outs", {24'd0, bus.grant, bus.req_ack},  32'd0);
        check("t6_rst_misc", {21'd0, bus.tx_start, bus.tx_data, bus.busy, bus.err}, 32'd0);
        rst = 1'b0;
        step();
        check("t6_grant_b", 32'(bus.grant), 32'b0100);
        check("t6_data_b", 32'(bus.tx_data), 32'h22);
        bus.req[2] = 1'b0;

        // random traffic with occasional resets
        do_reset();
        rand_mode = 1;
        for (int c = 0; c < 8000; c++) begin
            step();
            if ($urandom_range(0, 699) == 0) begin
                rst = 1'b1; inflight = 0; bus.tx_done = 1'b0;
            end else begin
                rst = 1'b0;
            end
        end
        rand_mode = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (legal 2..8).
REQ-002 Parameter DW, default 8, byte width sent to the UART transmitter.
REQ-003 Parameter GAP_CYC, default 2, idle clk cycles inserted after each tx_done (0 = no gap).
REQ-004 Parameter HOLD_TO, default 1024, clk cycles allowed mid-message for the owner to present its next byte.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req  in  NREQ  requester i has a byte valid on req_data.
REQ-008 req_data  in  NREQ*DW  byte of requester i at bits [i*DW +: DW].
REQ-009 req_last  in  NREQ  byte of requester i is the last of its message.
REQ-010 req_ack  out  NREQ  one-cycle pulse, byte of requester i accepted.
REQ-011 grant  out  NREQ  one-hot current owner; all-zero when idle.
REQ-012 tx_start  out  1  one-cycle pulse launching one UART frame.
REQ-013 tx_data  out  DW  byte for the UART transmitter; stable from tx_start until tx_done.
REQ-014 tx_done  in  1  one-cycle pulse from the transmitter after the stop bit.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 err  out  1  one-cycle pulse on hold timeout abort.

Function
REQ-017 The block SHALL implement states IDLE, LOAD, WAIT, GAP, HOLD; all outputs registered.
REQ-018 IDLE: any req high -> LOAD; on that edge grant, owner, tx_data <= req_data[winner] and last_r <= req_last[winner] are captured.
REQ-019 Winner SHALL be the first asserted req searching upward from pointer ptr, modulo NREQ.
REQ-020 LOAD lasts exactly one cycle: tx_start=1, req_ack=grant; then -> WAIT.
REQ-021 Latency: req sampled high in IDLE at edge n -> tx_start and req_ack high in cycle n+1.
REQ-022 Requesters SHALL hold req, req_data and req_last stable until req_ack; the block never acks a non-owner.
REQ-023 WAIT: on tx_done -> GAP (or directly to the GAP exit target when GAP_CYC=0); tx_done in any other state is ignored.
REQ-024 GAP: count GAP_CYC cycles, then -> HOLD if last_r=0, else -> IDLE, clearing grant and setting ptr <= (owner+1) mod NREQ.
REQ-025 HOLD (message lock): other requesters are not arbitrated; req[owner] high -> LOAD, capturing tx_data and last_r from the owner only.
REQ-026 HOLD timeout: HOLD_TO consecutive cycles without req[owner] -> err pulse, grant cleared, ptr <= owner+1, -> IDLE.
REQ-027 The hold counter SHALL clear on every entry to HOLD; the width of every counter SHALL hold its maximum value without wrap.
REQ-028 Simultaneous requests SHALL resolve in the same cycle per REQ-019; a request arriving during a message waits until release.
REQ-029 tx_data SHALL change only on entry to LOAD.
REQ-030 Last and non-last bytes SHALL be treated identically by LOAD and WAIT; the distinction applies only at GAP exit.

Reset
REQ-031 rst high at any edge SHALL force IDLE, ptr=0, grant=0, req_ack=0, tx_start=0, tx_data=0, busy=0, err=0, all counters=0.
REQ-032 Reset mid-frame SHALL abort without issuing a further tx_start; the transmitter is reset by the same rst.
REQ-033 In the first cycle after rst falls, a pending req SHALL be handled per REQ-018.

Verification
REQ-034 Single byte: req[1]=1, req_data[1]=0x4A, req_last[1]=1 -> next cycle tx_start=1, req_ack=0010, tx_data=0x4A; tx_done -> 2 gap cycles -> IDLE, grant=0, ptr=2.
REQ-035 Round-robin: req=1111 held with single-byte messages from reset -> grant order 0,1,2,3,0; each req_ack one cycle, one per frame.
REQ-036 Message lock: req[0] sends 3 bytes "J","1",0x0D (last on third) while req[2] is high -> three frames from 0 back-to-back with GAP_CYC between them, then grant=0100.
REQ-037 Hold timeout: owner 3 sends a non-last byte then drops req -> after exactly HOLD_TO cycles in HOLD, err pulses once, grant=0, ptr=0.
REQ-038 Stray tx_done: tx_done pulsed in IDLE and in LOAD -> no state change, no req_ack.
REQ-039 Reset mid-WAIT: rst pulsed one cycle during a frame -> next cycle all outputs at REQ-031 values; pending req[2] then starts with grant=0100.
